// File: rtl/riscv_params_pkg.sv
// riscv_params_pkg
//   Shared SimpleRISC constants: opcode values (ADD=0 .. RET=20), the bit
//   positions of the instruction fields inside a 32-bit word, the highest
//   legal opcode, and the state type of the streaming encoder.
package riscv_params_pkg;

  // Opcode values
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_MOV  = 5'd9;
  localparam logic [4:0] OP_LSL  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_NOP  = 5'd13;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BGT  = 5'd17;
  localparam logic [4:0] OP_B    = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;

  // Field bit positions
  localparam int OPC_LSB = 27;
  localparam int IBIT    = 26;
  localparam int RD_LSB  = 22;
  localparam int RS1_LSB = 18;
  localparam int RS2_LSB = 14;

  // Opcodes above this value are illegal
  localparam logic [4:0] LAST_OPCODE = 5'd20;

  // Encoder control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

endpackage

// File: rtl/simple_risc_encoder_encode.sv
// simple_risc_encode
//   Purely combinational packer: decoded SimpleRISC fields in, one 32-bit
//   instruction word out.
//   Ports:
//     opcode_i, ibit_i, rd_i, rs1_i, rs2_i, imm_i, offset_i : decoded fields
//     instr_o      : packed instruction (zero when the opcode is illegal)
//     is_illegal_o : opcode is above LAST_OPCODE
module simple_risc_encode
  import riscv_params_pkg::*;
(
  input  logic [4:0]  opcode_i,
  input  logic        ibit_i,
  input  logic [3:0]  rd_i,
  input  logic [3:0]  rs1_i,
  input  logic [3:0]  rs2_i,
  input  logic [17:0] imm_i,
  input  logic [26:0] offset_i,
  output logic [31:0] instr_o,
  output logic        is_illegal_o
);

  logic        ibit;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [17:0] op2;

  always_comb begin
    ibit         = ibit_i;
    rd           = rd_i;
    rs1          = rs1_i;
    op2          = '0;
    instr_o      = '0;
    is_illegal_o = (opcode_i > LAST_OPCODE);

    // Per-opcode field overrides for the three-address format
    case (opcode_i)
      OP_CMP:         rd   = '0;
      OP_NOT, OP_MOV: rs1  = '0;
      OP_LD, OP_ST:   ibit = 1'b1;   // memory ops always take an immediate
      default: ;
    endcase

    // Operand 2: immediate (with modifier) or rs2 left-aligned in [17:14]
    op2 = ibit ? imm_i : {rs2_i, {RS2_LSB{1'b0}}};

    instr_o[OPC_LSB +: 5]     = opcode_i;
    instr_o[IBIT]             = ibit;
    instr_o[RD_LSB +: 4]      = rd;
    instr_o[RS1_LSB +: 4]     = rs1;
    instr_o[RS1_LSB-1:0]      = op2;

    // Formats that replace everything below the opcode
    case (opcode_i)
      OP_NOP, OP_RET:                instr_o[OPC_LSB-1:0] = '0;
      OP_B, OP_BEQ, OP_BGT, OP_CALL: instr_o[OPC_LSB-1:0] = offset_i;
      default: ;
    endcase

    if (is_illegal_o) begin
      instr_o = '0;
    end
  end

endmodule

// File: rtl/simple_risc_encoder.sv
// simple_risc_encoder
//   Streaming SimpleRISC encoder / program loader. Accepts decoded fields,
//   packs them into 32-bit words and emits each with a sequential byte address
//   toward an instruction-memory write port.
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     start                    : begin a load (only honoured while idle)
//     in_valid/in_ready        : input field handshake
//     in_opcode..in_offset     : decoded instruction fields
//     in_last                  : final instruction of the program
//     out_valid/out_ready      : output word handshake
//     out_addr, out_instr      : byte address and encoded word
//     busy, done               : not idle / one-cycle end-of-load pulse
//     illegal                  : sticky, an opcode above 20 was consumed
//     instr_count              : words emitted, saturating
//     dbg_state                : current controller state (debug)
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. While out_valid is high and out_ready low, out_instr and
//   out_addr hold. in_ready never depends on in_valid.
module simple_risc_encoder
  import riscv_params_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned        CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic              in_ibit,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  input  logic [17:0]       in_imm,
  input  logic [26:0]       in_offset,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_instr,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [CNT_W-1:0]  instr_count,
  output logic [1:0]        dbg_state
);

  enc_state_e        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              illegal_q, illegal_d;

  logic [31:0]       enc_instr;
  logic              enc_illegal;
  logic              accept;
  logic              out_hs;

  simple_risc_encode u_encode (
    .opcode_i     (in_opcode),
    .ibit_i       (in_ibit),
    .rd_i         (in_rd),
    .rs1_i        (in_rs1),
    .rs2_i        (in_rs2),
    .imm_i        (in_imm),
    .offset_i     (in_offset),
    .instr_o      (enc_instr),
    .is_illegal_o (enc_illegal)
  );

  // The output stage can take a new word when empty or emptying this cycle
  assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    addr_d      = addr_q;
    count_d     = count_q;
    illegal_d   = illegal_q;

    // out_addr always names the pending (or next) word, so it advances
    // exactly once per output handshake, even when a new word loads
    if (out_hs) begin
      out_valid_d = 1'b0;
      addr_d      = addr_q + ADDR_W'(4);
      if (!(&count_q)) begin
        count_d = count_q + CNT_W'(1);
      end
    end

    // Illegal inputs are consumed without producing a word
    if (accept) begin
      if (enc_illegal) begin
        illegal_d = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_instr_d = enc_instr;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          addr_d    = BASE_ADDR;
          count_d   = '0;
          illegal_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (accept && in_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!out_valid_q || out_hs) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      addr_q      <= BASE_ADDR;
      count_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_addr    = addr_q;
  assign instr_count = count_q;
  assign illegal     = illegal_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_simple_risc_encoder.sv
// Testbench for simple_risc_encoder: directed program, backpressure,
// illegal last instruction, reset during drain and randomized streams
// checked against a field-level reference encoder.
module tb_simple_risc_encoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, in_ibit, in_last, out_ready;
  logic [4:0]  in_opcode;
  logic [3:0]  in_rd, in_rs1, in_rs2;
  logic [17:0] in_imm;
  logic [26:0] in_offset;
  logic        in_ready, out_valid, busy, done, illegal;
  logic [31:0] out_addr, out_instr;
  logic [7:0]  instr_count;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  simple_risc_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_ibit(in_ibit),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_offset(in_offset), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_instr(out_instr),
    .busy(busy), .done(done), .illegal(illegal),
    .instr_count(instr_count), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  // Builds the word from field weights; opcode classes decide which fields
  // survive.
  function automatic logic [31:0] model_word(input int opc, input int ib,
                                             input int rd, input int rs1,
                                             input int rs2, input int imm,
                                             input int off);
    int unsigned head;
    int unsigned op2;
    head = opc * 32'h0800_0000;
    if (opc == 13 || opc == 20) return head;
    if (opc >= 16 && opc <= 19) return head + off;
    if (opc == 14 || opc == 15) ib = 1;
    if (opc == 5) rd = 0;
    if (opc == 8 || opc == 9) rs1 = 0;
    op2 = (ib != 0) ? imm : rs2 * 16384;
    return head + ib * 32'h0400_0000 + rd * 32'h0040_0000 + rs1 * 32'h0004_0000 + op2;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_fields(input int opc, input int ib, input int rd,
                            input int rs1, input int rs2, input int imm,
                            input int off, input bit last);
    in_opcode = opc[4:0];
    in_ibit   = ib[0];
    in_rd     = rd[3:0];
    in_rs1    = rs1[3:0];
    in_rs2    = rs2[3:0];
    in_imm    = imm[17:0];
    in_offset = off[26:0];
    in_last   = last;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits up to max_cyc cycles, counting done pulses; leaves at a negedge
  task automatic wait_done(input int max_cyc, output int pulses);
    pulses = 0;
    for (int k = 0; k < max_cyc; k++) begin
      #1;
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL reset_out_instr: got %h expected 00000000", out_instr); end
    n_vec++; if (out_addr !== 32'h0) begin n_err++; $display("FAIL reset_out_addr: got %h expected 00000000", out_addr); end
    n_vec++; if (instr_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
    n_vec++; if ({illegal, done, busy, in_ready} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b expected 0000", {illegal, done, busy, in_ready}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] exp_w[5];
    int f[5][7];
    int pulses;
    exp_w = '{32'h0048C000, 32'h4D401234, 32'h74480008, 32'h98000010, 32'hA0000000};
    f[0] = '{0, 0, 1, 2, 3, 0, 0};
    f[1] = '{9, 1, 5, 7, 0, 32'h01234, 0};
    f[2] = '{14, 0, 1, 2, 0, 8, 0};
    f[3] = '{19, 0, 0, 0, 0, 0, 32'h10};
    f[4] = '{20, 0, 3, 4, 5, 32'h3FFFF, 32'h7FFFFFF};
    out_ready = 1'b1;
    do_start();
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        set_fields(f[i][0], f[i][1], f[i][2], f[i][3], f[i][4], f[i][5], f[i][6], i == 4);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_instr !== exp_w[i-1] || out_addr !== 32'(4 * (i - 1))) begin
          n_err++;
          $display("FAIL directed_word%0d: got v=%b %h @%h expected v=1 %h @%h",
                   i - 1, out_valid, out_instr, out_addr, exp_w[i-1], 32'(4 * (i - 1)));
        end
      end
      if (i < 5) begin
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL directed_in_ready%0d: got %b expected 1", i, in_ready); end
      end
      @(negedge clk);
    end
    wait_done(6, pulses);
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL directed_done: got %0d pulses expected 1", pulses); end
    n_vec++; if (instr_count !== 8'd5) begin n_err++; $display("FAIL directed_count: got %0d expected 5", instr_count); end
  endtask

  task automatic test_backpressure();
    int pulses;
    out_ready = 1'b0;
    do_start();
    set_fields(13, 1, 3, 3, 3, 5, 9, 1'b0);
    in_valid = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_first_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== 32'h68000000 || out_addr !== 32'h0) begin
        n_err++;
        $display("FAIL bp_hold%0d: got rdy=%b v=%b %h @%h expected rdy=0 v=1 68000000 @00000000",
                 c, in_ready, out_valid, out_instr, out_addr);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    in_last = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b1 || out_addr !== 32'h4 || out_instr !== 32'h68000000) begin
      n_err++; $display("FAIL bp_word1: got v=%b %h @%h expected v=1 68000000 @00000004", out_valid, out_instr, out_addr);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b1 || out_addr !== 32'h8) begin
      n_err++; $display("FAIL bp_word2: got v=%b @%h expected v=1 @00000008", out_valid, out_addr);
    end
    @(negedge clk);
    wait_done(5, pulses);
    n_vec++; if (instr_count !== 8'd3) begin n_err++; $display("FAIL bp_count: got %0d expected 3", instr_count); end
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL bp_done: got %0d pulses expected 1", pulses); end
  endtask

  task automatic test_illegal_last();
    int pulses;
    out_ready = 1'b1;
    do_start();
    set_fields(31, 0, 1, 1, 1, 1, 1, 1'b1);
    in_valid = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ill_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || illegal !== 1'b1 || instr_count !== 8'd0 || out_addr !== 32'h0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL ill_state: got v=%b ill=%b cnt=%0d @%h busy=%b expected v=0 ill=1 cnt=0 @00000000 busy=1",
               out_valid, illegal, instr_count, out_addr, busy);
    end
    @(negedge clk);
    #1;
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL ill_done_timing: got %b expected 1", done); end
    @(negedge clk);
    wait_done(4, pulses);
    n_vec++; if (pulses != 0 || busy !== 1'b0 || illegal !== 1'b1) begin
      n_err++; $display("FAIL ill_after: got extra_done=%0d busy=%b ill=%b expected 0 0 1", pulses, busy, illegal);
    end
  endtask

  task automatic test_reset_mid_load();
    int pulses;
    out_ready = 1'b0;
    do_start();
    set_fields(25, 0, 0, 0, 0, 0, 0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    set_fields(0, 0, 1, 2, 3, 0, 0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b1 || illegal !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL rml_pre: got v=%b ill=%b busy=%b expected 1 1 1", out_valid, illegal, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_addr !== 32'h0 || instr_count !== 8'd0 ||
        illegal !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rml_reset: got v=%b %h @%h cnt=%0d ill=%b done=%b busy=%b rdy=%b expected all zero",
               out_valid, out_instr, out_addr, instr_count, illegal, done, busy, in_ready);
    end
    @(negedge clk);
    out_ready = 1'b1;
    do_start();
    set_fields(0, 0, 1, 2, 3, 0, 0, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b1 || out_instr !== 32'h0048C000 || out_addr !== 32'h0) begin
      n_err++; $display("FAIL rml_restart: got v=%b %h @%h expected v=1 0048c000 @00000000", out_valid, out_instr, out_addr);
    end
    @(negedge clk);
    wait_done(5, pulses);
  endtask

  // Random stream: random fields, valid gaps, backpressure and stray starts
  task automatic run_stream(input int n, input int ill_pct, input int rdy_pct, input int vld_pct);
    int sent = 0, emitted = 0, dones = 0, cyc = 0;
    bit any_ill = 0, run_phase = 1, hold_prev = 0, acc;
    logic [31:0] held_instr, held_addr, e;
    int opc, ib, rd, rs1, rs2, imm, off;
    bit exp_rdy;
    exp_q.delete();
    in_valid = 1'b0;
    do_start();
    while (cyc < 4000) begin
      acc = 0;
      if (!in_valid && sent < n && $urandom_range(99) < vld_pct) begin
        opc = ($urandom_range(99) < ill_pct) ? $urandom_range(31, 21) : $urandom_range(20, 0);
        ib = $urandom_range(1); rd = $urandom_range(15); rs1 = $urandom_range(15);
        rs2 = $urandom_range(15); imm = $urandom_range(32'h3FFFF);
        off = $urandom_range(32'h7FFFFFF);
        set_fields(opc, ib, rd, rs1, rs2, imm, off, sent == n - 1);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      start = ($urandom_range(9) == 0);
      #1;
      if (hold_prev) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_instr !== held_instr || out_addr !== held_addr) begin
          n_err++; $display("FAIL rnd_hold: got v=%b %h @%h expected v=1 %h @%h",
                            out_valid, out_instr, out_addr, held_instr, held_addr);
        end
      end
      exp_rdy = run_phase && (!out_valid || out_ready);
      n_vec++;
      if (in_ready !== exp_rdy || busy !== 1'b1) begin
        n_err++; $display("FAIL rnd_ready_busy: got rdy=%b busy=%b expected rdy=%b busy=1", in_ready, busy, exp_rdy);
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rnd_unexpected_word: got %h expected none", out_instr);
        end else begin
          e = exp_q.pop_front();
          if (out_instr !== e || out_addr !== 32'(emitted * 4)) begin
            n_err++; $display("FAIL rnd_word%0d: got %h @%h expected %h @%h",
                              emitted, out_instr, out_addr, e, 32'(emitted * 4));
          end
        end
        emitted++;
      end
      if (in_valid && in_ready === 1'b1) begin
        if (opc > 20) any_ill = 1;
        else exp_q.push_back(model_word(opc, ib, rd, rs1, rs2, imm, off));
        sent++;
        if (in_last) run_phase = 0;
        acc = 1;
      end
      if (done === 1'b1) dones++;
      hold_prev = (out_valid === 1'b1) && !out_ready;
      held_instr = out_instr;
      held_addr = out_addr;
      @(negedge clk);
      cyc++;
      if (acc) in_valid = 1'b0;
      if (dones > 0) break;
    end
    start = 1'b0;
    n_vec++; if (dones != 1) begin n_err++; $display("FAIL rnd_timeout_or_done: got %0d done pulses expected 1", dones); end
    #1;
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd_leftover: got %0d words pending expected 0", exp_q.size()); end
    n_vec++; if (instr_count !== 8'(emitted > 255 ? 255 : emitted)) begin
      n_err++; $display("FAIL rnd_count: got %0d expected %0d", instr_count, emitted > 255 ? 255 : emitted);
    end
    n_vec++; if (illegal !== any_ill || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL rnd_end_flags: got ill=%b busy=%b done=%b expected ill=%b busy=0 done=0", illegal, busy, done, any_ill);
    end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_illegal_last();
    test_reset_mid_load();
    run_stream(40, 0, 70, 80);
    run_stream(60, 15, 50, 60);
    run_stream(30, 30, 100, 100);
    run_stream(300, 0, 100, 100);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
